// File: rtl/vga_fb_pkg.sv
// Package for the scaled QSPI framebuffer VGA driver.
// Holds the standard 640x480@60 timing constants and small helpers used
// to derive line/frame totals and counter widths from timing parameters.
package vga_fb_pkg;

    // Standard 640x480 timing, in pixel clocks / lines
    localparam int STD_H_VIS  = 640;
    localparam int STD_H_FP   = 16;
    localparam int STD_H_SYNC = 96;
    localparam int STD_H_BP   = 48;
    localparam int STD_V_VIS  = 480;
    localparam int STD_V_FP   = 10;
    localparam int STD_V_SYNC = 2;
    localparam int STD_V_BP   = 33;

    // Total period of one axis (line length or frame height)
    function automatic int calc_tot(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    // Bits needed to count 0..n-1 (at least 1)
    function automatic int ctr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_fb_timing_gen.sv
// vga_timing_gen: horizontal/vertical raster counters and sync generation.
//
// All outputs are registered and describe the CURRENT raster position:
// they are loaded from the position the counters are about to enter, so
// h_sync/v_sync/h_vis/v_vis line up with the counter value in the same cycle.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   h_pos, v_pos    position the raster enters on the next clock edge
//                   (lets the parent register its own aligned outputs)
//   h_sync, v_sync  registered sync outputs with configurable polarity
//   h_vis, v_vis    registered visible-area flags for the current position
module vga_timing_gen
    import vga_fb_pkg::*;
#(
    parameter int H_VIS     = STD_H_VIS,
    parameter int H_FP      = STD_H_FP,
    parameter int H_SYNC    = STD_H_SYNC,
    parameter int H_BP      = STD_H_BP,
    parameter int V_VIS     = STD_V_VIS,
    parameter int V_FP      = STD_V_FP,
    parameter int V_SYNC    = STD_V_SYNC,
    parameter int V_BP      = STD_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int HW        = ctr_width(calc_tot(H_VIS, H_FP, H_SYNC, H_BP)),
    parameter int VW        = ctr_width(calc_tot(V_VIS, V_FP, V_SYNC, V_BP))
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [HW-1:0] h_pos,
    output logic [VW-1:0] v_pos,
    output logic          h_sync,
    output logic          v_sync,
    output logic          h_vis,
    output logic          v_vis
);

    localparam int H_TOT = calc_tot(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = calc_tot(V_VIS, V_FP, V_SYNC, V_BP);

    logic [HW-1:0] h_ctr;
    logic [VW-1:0] v_ctr;

    always_comb begin
        h_pos = h_ctr + HW'(1);
        v_pos = v_ctr;
        if (h_ctr == HW'(H_TOT - 1)) begin
            h_pos = '0;
            v_pos = (v_ctr == VW'(V_TOT - 1)) ? '0 : v_ctr + VW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_ctr  <= '0;
            v_ctr  <= '0;
            h_sync <= !HSYNC_POL;
            v_sync <= !VSYNC_POL;
            h_vis  <= 1'b1;      // position 0,0 is visible
            v_vis  <= 1'b1;
        end else begin
            h_ctr  <= h_pos;
            v_ctr  <= v_pos;
            h_sync <= (h_pos >= HW'(H_VIS + H_FP) && h_pos < HW'(H_VIS + H_FP + H_SYNC))
                      ? HSYNC_POL : !HSYNC_POL;
            v_sync <= (v_pos >= VW'(V_VIS + V_FP) && v_pos < VW'(V_VIS + V_FP + V_SYNC))
                      ? VSYNC_POL : !VSYNC_POL;
            h_vis  <= (h_pos < HW'(H_VIS));
            v_vis  <= (v_pos < VW'(V_VIS));
        end
    end

endmodule

// File: rtl/vga_qspi_framebuffer_scaled.sv
// vga_qspi_framebuffer_scaled: VGA scan-out from an external QSPI framebuffer
// with horizontal/vertical pixel replication, plus a registered pass-through
// of the framebuffer writer's interface.
//
// Optional build macro VGA_TEST_PATTERN_EN adds input test_mode, which shows
// a horizontal ramp (h >> 3) and suppresses framebuffer reads.
//
// Handshake: rd_req is a one-cycle strobe with no back-pressure. Data for a
// strobe raised in cycle t is sampled from data_in at the clock edge that
// ends cycle t+FETCH_LAT-1, so it is on gray_out FETCH_LAT cycles after the
// strobe. line_rewind / frame_start are one-cycle pointer commands.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   h_sync, v_sync     sync outputs
//   gray_out           pixel value, 0 when blanked
//   data_in, rd_req    framebuffer read data and fetch strobe
//   line_rewind        replay the current line (vertical replication)
//   frame_start        reset the read pointer to 0
//   wr_*_in / wr_*_out writer interface, forwarded through one register
//   wr_ack             wr_strobe_in delayed one cycle
module vga_qspi_framebuffer_scaled
    import vga_fb_pkg::*;
#(
    parameter int H_VIS     = STD_H_VIS,
    parameter int H_FP      = STD_H_FP,
    parameter int H_SYNC    = STD_H_SYNC,
    parameter int H_BP      = STD_H_BP,
    parameter int V_VIS     = STD_V_VIS,
    parameter int V_FP      = STD_V_FP,
    parameter int V_SYNC    = STD_V_SYNC,
    parameter int V_BP      = STD_V_BP,
    parameter int PIX_W     = 4,
    parameter int H_SCALE   = 1,
    parameter int V_SCALE   = 1,
    parameter int FETCH_LAT = 2,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef VGA_TEST_PATTERN_EN
    input  logic             test_mode,
`endif
    output logic             h_sync,
    output logic             v_sync,
    output logic [PIX_W-1:0] gray_out,
    input  logic [PIX_W-1:0] data_in,
    output logic             rd_req,
    output logic             line_rewind,
    output logic             frame_start,
    input  logic [PIX_W-1:0] wr_data_in,
    input  logic             wr_strobe_in,
    input  logic             wr_ptr_reset_in,
    output logic [PIX_W-1:0] wr_data_out,
    output logic             wr_strobe_out,
    output logic             wr_ptr_reset_out,
    output logic             wr_ack
);

    localparam int H_TOT = calc_tot(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = calc_tot(V_VIS, V_FP, V_SYNC, V_BP);
    localparam int HW    = ctr_width(H_TOT);
    localparam int VW    = ctr_width(V_TOT);

    logic [HW-1:0]        h_pos;
    logic [VW-1:0]        v_pos;
    logic                 h_vis, v_vis;
    logic [HW-1:0]        tgt_h;
    logic [VW-1:0]        tgt_v;
    logic                 wrapped;
    logic                 fetch_hit;
    logic                 req_next;
    logic [FETCH_LAT-1:0] req_pipe;
    logic [PIX_W-1:0]     pix_reg;

    vga_timing_gen #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL), .HW(HW), .VW(VW)
    ) u_timing (
        .clk    (clk),
        .rst_n  (rst_n),
        .h_pos  (h_pos),
        .v_pos  (v_pos),
        .h_sync (h_sync),
        .v_sync (v_sync),
        .h_vis  (h_vis),
        .v_vis  (v_vis)
    );

    // A fetch issued at position h targets the pixel FETCH_LAT clocks later.
    // Near the line end that target wraps into the next line (and past the
    // last line into line 0), which is why the target line is derived too.
    always_comb begin
        wrapped = (h_pos >= HW'(H_TOT - FETCH_LAT));
        if (wrapped) begin
            tgt_h = h_pos - HW'(H_TOT - FETCH_LAT);
            tgt_v = (v_pos == VW'(V_TOT - 1)) ? '0 : v_pos + VW'(1);
        end else begin
            tgt_h = h_pos + HW'(FETCH_LAT);
            tgt_v = v_pos;
        end
        fetch_hit = (tgt_h < HW'(H_VIS)) && ((tgt_h % HW'(H_SCALE)) == '0)
                    && (tgt_v < VW'(V_VIS));
`ifdef VGA_TEST_PATTERN_EN
        req_next = fetch_hit && !test_mode;
`else
        req_next = fetch_hit;
`endif
    end

    // req_pipe[0] is the strobe itself; the top bit marks the cycle whose
    // ending edge captures the returned data.
    assign rd_req   = req_pipe[0];
    assign gray_out = (h_vis && v_vis) ? pix_reg : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_pipe    <= '0;
            pix_reg     <= '0;
            line_rewind <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            req_pipe    <= (req_pipe << 1) | FETCH_LAT'(req_next);
`ifdef VGA_TEST_PATTERN_EN
            if (test_mode)
                pix_reg <= PIX_W'({8'd0, h_pos} >> 3);
            else if (req_pipe[FETCH_LAT-1])
                pix_reg <= data_in;
`else
            if (req_pipe[FETCH_LAT-1])
                pix_reg <= data_in;
`endif
            line_rewind <= (h_pos == HW'(H_VIS)) && (v_pos < VW'(V_VIS))
                           && ((v_pos % VW'(V_SCALE)) != VW'(V_SCALE - 1));
            frame_start <= (h_pos == '0) && (v_pos == VW'(V_VIS + V_FP));
        end
    end

    // Writer path: plain one-cycle forward, independent of the raster.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_data_out      <= '0;
            wr_strobe_out    <= 1'b0;
            wr_ptr_reset_out <= 1'b0;
            wr_ack           <= 1'b0;
        end else begin
            wr_data_out      <= wr_data_in;
            wr_strobe_out    <= wr_strobe_in;
            wr_ptr_reset_out <= wr_ptr_reset_in;
            wr_ack           <= wr_strobe_in;
        end
    end

endmodule

// File: tb/tb_vga_qspi_framebuffer_scaled.sv
// Testbench for vga_qspi_framebuffer_scaled using a reduced raster
// (48x15 clocks) with H_SCALE=2, V_SCALE=2, FETCH_LAT=3 and mixed sync
// polarities. A framebuffer controller model answers rd_req from a random
// image, honours line_rewind/frame_start, and every cycle is compared with
// positions computed from the raster rules.
module tb_vga_qspi_framebuffer_scaled;

    localparam int H_VIS = 32, H_FP = 4, H_SYNC = 6, H_BP = 6;
    localparam int V_VIS = 8,  V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam int PIX_W = 4, H_SCALE = 2, V_SCALE = 2, FETCH_LAT = 3;
    localparam bit HSYNC_POL = 1'b0, VSYNC_POL = 1'b1;
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int PPL = H_VIS / H_SCALE;
    localparam int FB_LINES = V_VIS / V_SCALE;
    localparam int FB_SIZE = PPL * FB_LINES;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             h_sync, v_sync, rd_req, line_rewind, frame_start;
    logic [PIX_W-1:0] gray_out, data_in, wr_data_in, wr_data_out;
    logic             wr_strobe_in, wr_ptr_reset_in, wr_strobe_out, wr_ptr_reset_out, wr_ack;
`ifdef VGA_TEST_PATTERN_EN
    logic test_mode = 1'b0;
`endif

    vga_qspi_framebuffer_scaled #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .PIX_W(PIX_W), .H_SCALE(H_SCALE), .V_SCALE(V_SCALE), .FETCH_LAT(FETCH_LAT),
        .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode        (test_mode),
`endif
        .h_sync           (h_sync),
        .v_sync           (v_sync),
        .gray_out         (gray_out),
        .data_in          (data_in),
        .rd_req           (rd_req),
        .line_rewind      (line_rewind),
        .frame_start      (frame_start),
        .wr_data_in       (wr_data_in),
        .wr_strobe_in     (wr_strobe_in),
        .wr_ptr_reset_in  (wr_ptr_reset_in),
        .wr_data_out      (wr_data_out),
        .wr_strobe_out    (wr_strobe_out),
        .wr_ptr_reset_out (wr_ptr_reset_out),
        .wr_ack           (wr_ack)
    );

    // scoreboard / model state
    int tests = 0;
    int fails = 0;
    int n;                          // cycles since reset release (0 = first cycle)
    bit after_rst;
    int rp;                         // controller read pointer
    int rew_cnt, fs_cnt;
    logic [PIX_W-1:0] fb [FB_SIZE];
    logic [PIX_W-1:0] exp_q[$];     // data the controller still has to return
    int due_q[$];                   // cycle in which each entry is driven
    logic [PIX_W-1:0] prev_wd;
    logic prev_ws, prev_wp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    // rd_req expected at (h,v): some pixel k sits FETCH_LAT clocks later,
    // possibly on the next line, and that line is visible.
    function automatic bit exp_rd(input int h, input int v);
        for (int k = 0; k < PPL; k++) begin
            int raw;
            int eh;
            int tv;
            raw = k * H_SCALE - FETCH_LAT;
            eh  = ((raw % H_TOT) + H_TOT) % H_TOT;
            tv  = (raw < 0) ? (v + 1) % V_TOT : v;
            if (eh == h && tv < V_VIS) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        n = 0;
        rp = 0;
        rew_cnt = 0;
        fs_cnt = 0;
        exp_q.delete();
        due_q.delete();
        prev_wd = '0;
        prev_ws = 1'b0;
        prev_wp = 1'b0;
        after_rst = 1'b1;
    endtask

    // Called at the negedge of cycle n: check, then drive inputs for its edge.
    task automatic step();
        int h, v, frame;
        logic [PIX_W-1:0] dval, wd;
        logic ws, wp;
        h = n % H_TOT;
        v = (n / H_TOT) % V_TOT;
        frame = n / FRAME;

        if (after_rst) begin
            check("rst_gray", gray_out, '0);
            check("rst_rd_req", rd_req, 1'b0);
            check("rst_rewind", line_rewind, 1'b0);
            check("rst_frame_start", frame_start, 1'b0);
            check("rst_wr", {wr_data_out, wr_strobe_out, wr_ptr_reset_out, wr_ack}, '0);
            check("rst_h_sync", h_sync, !HSYNC_POL);
            check("rst_v_sync", v_sync, !VSYNC_POL);
            after_rst = 1'b0;
        end

        check("h_sync", h_sync,
              (h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC) ? HSYNC_POL : !HSYNC_POL);
        check("v_sync", v_sync,
              (v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC) ? VSYNC_POL : !VSYNC_POL);
        check("rd_req", rd_req, exp_rd(h, v));
        check("line_rewind", line_rewind,
              (h == H_VIS && v < V_VIS && (v % V_SCALE) != V_SCALE - 1));
        check("frame_start", frame_start, (h == 0 && v == V_VIS + V_FP));
        if (h < H_VIS && v < V_VIS) begin
            if (frame >= 1)
                check("gray_out", gray_out, fb[(v / V_SCALE) * PPL + h / H_SCALE]);
        end else begin
            check("gray_blank", gray_out, '0);
        end
        check("wr_data_out", wr_data_out, prev_wd);
        check("wr_strobe_out", wr_strobe_out, prev_ws);
        check("wr_ptr_reset_out", wr_ptr_reset_out, prev_wp);
        check("wr_ack", wr_ack, prev_ws);

        // controller model
        if (rd_req === 1'b1) begin
            exp_q.push_back(fb[((rp % FB_SIZE) + FB_SIZE) % FB_SIZE]);
            due_q.push_back(n + FETCH_LAT - 1);
            rp++;
        end
        if (line_rewind === 1'b1) begin
            rp -= PPL;
            rew_cnt++;
        end
        if (frame_start === 1'b1) begin
            rp = 0;
            fs_cnt++;
        end
        if (h == H_TOT - 1 && v == V_TOT - 1) begin
            check("rewinds_per_frame", rew_cnt, FB_LINES * (V_SCALE - 1));
            check("frame_starts_per_frame", fs_cnt, 1);
            rew_cnt = 0;
            fs_cnt = 0;
        end

        dval = PIX_W'($urandom);
        if (due_q.size() > 0 && due_q[0] == n) begin
            dval = exp_q.pop_front();
            void'(due_q.pop_front());
        end
        data_in = dval;

        // writer stimulus, sometimes coincident with a read strobe
        wd = PIX_W'($urandom);
        ws = 1'($urandom_range(0, 1));
        wp = ($urandom_range(0, 3) == 0);
        if (rd_req === 1'b1 && $urandom_range(0, 1) == 1) begin
            wd = 4'hA;
            ws = 1'b1;
        end
        wr_data_in = wd;
        wr_strobe_in = ws;
        wr_ptr_reset_in = wp;
        prev_wd = wd;
        prev_ws = ws;
        prev_wp = wp;

        @(negedge clk);
        n++;
    endtask

    initial begin
        for (int i = 0; i < FB_SIZE; i++) fb[i] = PIX_W'($urandom);
        data_in = '0;
        wr_data_in = '0;
        wr_strobe_in = 1'b0;
        wr_ptr_reset_in = 1'b0;

        // power-on reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // three frames; stop at h=20, v=5 of the third
        while (n < 2 * FRAME + 5 * H_TOT + 20) step();

        // one-cycle mid-frame reset
        rst_n = 1'b0;
        data_in = '0;
        wr_data_in = '0;
        wr_strobe_in = 1'b0;
        wr_ptr_reset_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        while (n < 2 * FRAME + 10) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
